// File: rtl/alu_ctrl_if.sv
// Instruction and result channels between a sequencer client and alu_ctrl.
//   instr_*: valid/ready instruction channel (opcode, dst, source A/B regs)
//   res_*  : valid/ready result channel (data, dst, zero flag, error flag)
// master: issues instructions and consumes results; slave: the controller.
interface alu_ctrl_if;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned OP_W   = 3;

    logic              instr_valid;
    logic              instr_ready;
    logic [OP_W-1:0]   instr_op;
    logic [ADDR_W-1:0] instr_dst;
    logic [ADDR_W-1:0] instr_sa;
    logic [ADDR_W-1:0] instr_sb;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [ADDR_W-1:0] res_dst;
    logic              res_zero;
    logic              res_err;

    modport master (
        output instr_valid, instr_op, instr_dst, instr_sa, instr_sb, res_ready,
        input  instr_ready, res_valid, res_data, res_dst, res_zero, res_err
    );

    modport slave (
        input  instr_valid, instr_op, instr_dst, instr_sa, instr_sb, res_ready,
        output instr_ready, res_valid, res_data, res_dst, res_zero, res_err
    );
endinterface

// File: rtl/alu_ctrl.sv
// Sequencing front-end for the 4-bit combinational alu.
// Accepts register-to-register instructions, drives the ALU from registered
// operands, captures its result one cycle later, writes it back to a 4x4
// register file and returns it over the result channel.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : instruction / result handshake channels
//   ld_valid/addr/data: side load port into the register file (any state)
//   alu_oc/a/b        : registered drive to the alu
//   alu_f             : alu result
// Optional feature: define ALU_CTRL_DZ_GUARD_EN to force DIV by zero to 4'hF
// with res_err set; otherwise alu_f passes through and res_err stays 0.
module alu_ctrl #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned REGS   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_ctrl_if.slave                bus,
    input  logic                     ld_valid,
    input  logic [$clog2(REGS)-1:0]  ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [2:0]               alu_oc,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_f
);
    localparam int unsigned ADDR_W = $clog2(REGS);
    localparam int unsigned OP_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] rf [REGS];

    logic [OP_W-1:0]   alu_oc_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [ADDR_W-1:0] dst_q;

    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic [ADDR_W-1:0] res_dst_q;
    logic              res_zero_q;
    logic              res_err_q;

    logic              instr_ready_c;
    logic              accept_c;
    logic              capture_c;
    logic              res_hs_c;
    logic [DATA_W-1:0] wb_data_c;
    logic              wb_err_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.instr_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (res_valid_q && bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake decode and write-back value (with optional divide-by-zero guard)
    always_comb begin
        instr_ready_c = rst_n && (state_q == IDLE);
        accept_c      = bus.instr_valid && instr_ready_c;
        capture_c     = (state_q == EXEC);
        res_hs_c      = res_valid_q && bus.res_ready;
`ifdef ALU_CTRL_DZ_GUARD_EN
        wb_data_c     = alu_f;
        wb_err_c      = 1'b0;
        if ((alu_oc_q == OP_W'(3)) && (alu_b_q == '0)) begin
            wb_data_c = '1;
            wb_err_c  = 1'b1;
        end
`else
        wb_data_c     = alu_f;
        wb_err_c      = 1'b0;
`endif
    end

    // Operand latch and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_oc_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            dst_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_dst_q   <= '0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                // Reads see the pre-edge rf, so a same-edge load is not visible here
                alu_oc_q <= bus.instr_op;
                alu_a_q  <= rf[bus.instr_sa];
                alu_b_q  <= rf[bus.instr_sb];
                dst_q    <= bus.instr_dst;
            end
            if (capture_c) begin
                res_valid_q <= 1'b1;
                res_data_q  <= wb_data_c;
                res_dst_q   <= dst_q;
                res_zero_q  <= (wb_data_c == '0);
                res_err_q   <= wb_err_c;
            end else if (res_hs_c) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // Register file: write-back is ordered after the load so it wins on a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REGS); i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ld_valid) begin
                rf[ld_addr] <= ld_data;
            end
            if (capture_c) begin
                rf[dst_q] <= wb_data_c;
            end
        end
    end

    assign bus.instr_ready = instr_ready_c;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_dst     = res_dst_q;
    assign bus.res_zero    = res_zero_q;
    assign bus.res_err     = res_err_q;

    assign alu_oc = alu_oc_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl with a behavioural model of the 4-bit alu.
module tb_alu_ctrl;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ld_valid;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [2:0] alu_oc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_f;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .alu_oc   (alu_oc),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_f    (alu_f)
    );

    // Behavioural alu; divide by zero returns 0
    always_comb begin
        case (alu_oc)
            3'd0:    alu_f = 4'(alu_a + alu_b);
            3'd1:    alu_f = 4'(alu_a - alu_b);
            3'd2:    alu_f = 4'(alu_a * alu_b);
            3'd3:    alu_f = (alu_b == 4'd0) ? 4'd0 : 4'(alu_a / alu_b);
            3'd4:    alu_f = ~alu_a;
            3'd5:    alu_f = alu_a ^ alu_b;
            3'd6:    alu_f = alu_a | alu_b;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    typedef struct {
        logic [2:0] op;
        logic [1:0] dst;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] data;
        logic       zero;
        logic       err;
    } vec_t;

    vec_t vt [10];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    // Presents an instruction and returns #1 after the accept edge
    task automatic issue(input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb);
        bit ok;
        ok = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_dst   = dst;
        bus.instr_sa    = sa;
        bus.instr_sb    = sb;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.instr_ready) ok = 1'b1;
            tick();
        end
        bus.instr_valid = 1'b0;
        if (!ok) begin
            failures++;
            checks++;
            $display("FAIL accept_timeout actual=0 expected=1");
        end
    endtask

    task automatic check_result(input string tag, input vec_t e);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        chk({tag, "_res_data"},  32'(bus.res_data),  32'(e.data));
        chk({tag, "_res_dst"},   32'(bus.res_dst),   32'(e.dst));
        chk({tag, "_res_zero"},  32'(bus.res_zero),  32'(e.zero));
        chk({tag, "_res_err"},   32'(bus.res_err),   32'(e.err));
        chk({tag, "_rf_dst"},    32'(dut.rf[e.dst]), 32'(e.data));
    endtask

    task automatic finish_resp(input string tag);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_res_valid_clr"}, 32'(bus.res_valid),   32'd0);
        chk({tag, "_ready_back"},    32'(bus.instr_ready), 32'd1);
    endtask

    // Full instruction: operand drive, result capture, result handshake
    task automatic run_vec(input string tag, input vec_t e);
        issue(e.op, e.dst, e.sa, e.sb);
        chk({tag, "_alu_oc"},  32'(alu_oc), 32'(e.op));
        chk({tag, "_alu_a"},   32'(alu_a),  32'(e.a));
        chk({tag, "_alu_b"},   32'(alu_b),  32'(e.b));
        chk({tag, "_exec_rv"}, 32'(bus.res_valid),   32'd0);
        chk({tag, "_exec_ir"}, 32'(bus.instr_ready), 32'd0);
        tick();
        check_result(tag, e);
        finish_resp(tag);
    endtask

    initial begin
        ld_valid        = 1'b0;
        ld_addr         = '0;
        ld_data         = '0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_dst   = '0;
        bus.instr_sa    = '0;
        bus.instr_sb    = '0;
        bus.res_ready   = 1'b0;

        // rf starts {5,3,0,9}; later rows depend on earlier write-backs
        vt[0] = '{3'd0, 2'd2, 2'd0, 2'd1, 4'd5, 4'd3, 4'h8, 1'b0, 1'b0}; // ADD 5+3
        vt[1] = '{3'd1, 2'd2, 2'd1, 2'd0, 4'd3, 4'd5, 4'hE, 1'b0, 1'b0}; // SUB 3-5
        vt[2] = '{3'd2, 2'd2, 2'd0, 2'd3, 4'd5, 4'd9, 4'hD, 1'b0, 1'b0}; // MUL 5*9
        vt[3] = '{3'd4, 2'd2, 2'd0, 2'd1, 4'd5, 4'd3, 4'hA, 1'b0, 1'b0}; // NOT 5
        vt[4] = '{3'd5, 2'd2, 2'd0, 2'd0, 4'd5, 4'd5, 4'h0, 1'b1, 1'b0}; // XOR 5^5
`ifdef ALU_CTRL_DZ_GUARD_EN
        vt[5] = '{3'd3, 2'd2, 2'd3, 2'd2, 4'd9, 4'd0, 4'hF, 1'b0, 1'b1}; // DIV 9/0
`else
        vt[5] = '{3'd3, 2'd2, 2'd3, 2'd2, 4'd9, 4'd0, 4'h0, 1'b1, 1'b0}; // DIV 9/0
`endif
        vt[6] = '{3'd3, 2'd2, 2'd3, 2'd1, 4'd9, 4'd3, 4'h3, 1'b0, 1'b0}; // DIV 9/3
        vt[7] = '{3'd6, 2'd0, 2'd2, 2'd3, 4'd3, 4'd9, 4'hB, 1'b0, 1'b0}; // OR 3|9
        vt[8] = '{3'd7, 2'd3, 2'd0, 2'd3, 4'hB, 4'd9, 4'h9, 1'b0, 1'b0}; // AND B&9
        vt[9] = '{3'd0, 2'd1, 2'd3, 2'd3, 4'd9, 4'd9, 4'h2, 1'b0, 1'b0}; // ADD 9+9

        // Reset held for 3 cycles
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
            chk("rst_outputs", {21'd0, alu_oc, alu_a, alu_b, bus.res_data, bus.res_dst,
                                bus.res_valid, bus.res_zero, bus.res_err}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.instr_ready), 32'd1);
        load(2'd0, 4'd5);
        load(2'd1, 4'd3);
        load(2'd2, 4'd0);
        load(2'd3, 4'd9);
        chk("load_rf", {16'd0, dut.rf[3], dut.rf[2], dut.rf[1], dut.rf[0]}, 32'h9035);

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("v%0d", i), vt[i]);
        end
        // rf is now {B,2,3,9}

        // Backpressure: SUB 9-2 held for 4 cycles with a pending instruction
        v = '{3'd1, 2'd0, 2'd3, 2'd1, 4'd9, 4'd2, 4'h7, 1'b0, 1'b0};
        issue(v.op, v.dst, v.sa, v.sb);
        tick();
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'd0;
        for (int i = 0; i < 4; i++) begin
            check_result($sformatf("bp%0d", i), v);
            chk($sformatf("bp%0d_ir", i), 32'(bus.instr_ready), 32'd0);
            tick();
        end
        bus.instr_valid = 1'b0;
        finish_resp("bp");
        chk("bp_no_accept", 32'(alu_oc), 32'd1);

        // Load to dst on the capture edge: write-back wins (7+9 wraps to 0)
        v = '{3'd0, 2'd1, 2'd0, 2'd3, 4'd7, 4'd9, 4'h0, 1'b1, 1'b0};
        issue(v.op, v.dst, v.sa, v.sb);
        ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 4'd5;
        tick();
        ld_valid = 1'b0;
        check_result("wb_wins", v);
        finish_resp("wb_wins");

        // Load to a source register during EXEC: latched operands unaffected, both writes land
        v = '{3'd5, 2'd2, 2'd0, 2'd3, 4'd7, 4'd9, 4'hE, 1'b0, 1'b0};
        issue(v.op, v.dst, v.sa, v.sb);
        ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 4'd4;
        tick();
        ld_valid = 1'b0;
        check_result("src_ld", v);
        chk("src_ld_alu_a", 32'(alu_a), 32'd7);
        chk("src_ld_rf0", 32'(dut.rf[0]), 32'd4);
        finish_resp("src_ld");

        // Load on the accept edge: operand uses the old value
        v = '{3'd6, 2'd3, 2'd0, 2'd1, 4'd4, 4'd0, 4'h4, 1'b0, 1'b0};
        ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 4'd1;
        issue(v.op, v.dst, v.sa, v.sb);
        ld_valid = 1'b0;
        chk("acc_ld_alu_a", 32'(alu_a), 32'd4);
        chk("acc_ld_rf0", 32'(dut.rf[0]), 32'd1);
        tick();
        check_result("acc_ld", v);
        finish_resp("acc_ld");

        // Reset during EXEC: instruction discarded
        issue(3'd0, 2'd3, 2'd3, 2'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ir", 32'(bus.instr_ready), 32'd0);
        chk("mid_rst_alu", {24'd0, alu_a, alu_b}, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid_rst_rv%0d", i), 32'(bus.res_valid), 32'd0);
        end
        bus.res_ready = 1'b0;
        chk("mid_rst_rf", {16'd0, dut.rf[3], dut.rf[2], dut.rf[1], dut.rf[0]}, 32'd0);
        load(2'd0, 4'd6);
        load(2'd1, 4'd2);
        run_vec("post_rst", '{3'd2, 2'd2, 2'd0, 2'd1, 4'd6, 4'd2, 4'hC, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
